// File: rtl/nebula_sched_pkg.sv
// Shared types for the Nebula dispatch scheduler: block payload, FSM states
// and payload widths.
package nebula_sched_pkg;

  localparam int unsigned ID_W    = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WORDS   = 4;

  typedef logic [WORDS-1:0][WORD_W-1:0] blk_data_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    blk_data_t       data;
  } block_t;

  localparam int unsigned BLOCK_W = $bits(block_t);

  typedef enum logic [1:0] {
    IDLE,
    PAR_DRAIN,
    PAR_RUN
  } sched_state_e;

endpackage

// File: rtl/nebula_dispatch_sched_if.sv
// IFE-side and core-side signal bundle of the dispatch scheduler.
interface nebula_dispatch_sched_if;
  import nebula_sched_pkg::*;

  logic             ser_valid;
  logic             ser_ready;
  logic [ID_W-1:0]  ser_id;
  blk_data_t        ser_data;

  logic             par_valid;
  logic             par_ready;
  logic [ID_W-1:0]  par_id;
  blk_data_t        par_data0;
  blk_data_t        par_data1;

  logic [1:0]       core_busy;
  logic [1:0]       core_commit;
  logic [1:0]       core_valid;
  logic [ID_W-1:0]  core_id0;
  logic [ID_W-1:0]  core_id1;
  blk_data_t        core_data0;
  blk_data_t        core_data1;

  logic             commit_valid;
  logic [ID_W-1:0]  commit_id;
  logic             commit_par;
  logic             timeout_err;

  // Environment side: IFE plus the two cores.
  modport master (
    output ser_valid, ser_id, ser_data,
    output par_valid, par_id, par_data0, par_data1,
    output core_busy, core_commit,
    input  ser_ready, par_ready,
    input  core_valid, core_id0, core_id1, core_data0, core_data1,
    input  commit_valid, commit_id, commit_par, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  ser_valid, ser_id, ser_data,
    input  par_valid, par_id, par_data0, par_data1,
    input  core_busy, core_commit,
    output ser_ready, par_ready,
    output core_valid, core_id0, core_id1, core_data0, core_data1,
    output commit_valid, commit_id, commit_par, timeout_err
  );

endinterface

// File: rtl/nebula_dispatch_sched_block_fifo.sv
// Synchronous show-ahead FIFO of serial blocks; head is valid whenever !empty.
module sched_block_fifo
  import nebula_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  block_t push_blk,
  input  logic   pop,
  output block_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  block_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push_c;
  logic            do_pop_c;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign head      = mem[rd_ptr];

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= push_blk;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

endmodule

// File: rtl/nebula_dispatch_sched.sv
// Dispatch scheduler between the IFE and the two Nebula cores.
// Optional parallel-run watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module nebula_dispatch_sched
  import nebula_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                    clk,
  input logic                    rst,
  nebula_dispatch_sched_if.slave bus
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("nebula_dispatch_sched: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES > 0");
  end

  sched_state_e         state;
  logic [1:0]           inflight;
  logic [1:0]           core_valid_q;
  logic [1:0][ID_W-1:0] core_id_q;
  blk_data_t            core_data0_q;
  blk_data_t            core_data1_q;
  logic                 pend_valid;
  logic [ID_W-1:0]      pend_id;
  logic                 commit_valid_q;
  logic [ID_W-1:0]      commit_id_q;
  logic                 commit_par_q;
  logic                 par_ready_q;

  logic                 fifo_push_c;
  logic                 fifo_pop_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  block_t               push_blk_c;
  block_t               fifo_head;

  logic [1:0]           free_c;
  logic [1:0]           done_c;
  logic [1:0]           set_c;
  logic [1:0]           inflight_nxt_c;
  logic                 par_go_c;
  logic                 ser_core_c;
  logic                 to_hit_c;

  assign push_blk_c  = '{id: bus.ser_id, data: bus.ser_data};
  assign fifo_push_c = bus.ser_valid && !fifo_full;

  sched_block_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push_c),
    .push_blk (push_blk_c),
    .pop      (fifo_pop_c),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Dispatch decision; a held core-1 commit keeps core 1 unavailable.
  always_comb begin
    free_c         = ~bus.core_busy & ~inflight & {~pend_valid, 1'b1};
    done_c         = bus.core_commit & inflight;
    par_go_c       = 1'b0;
    fifo_pop_c     = 1'b0;
    ser_core_c     = 1'b0;
    set_c          = 2'b00;
    if ((state == IDLE || state == PAR_DRAIN) && bus.par_valid && (&free_c) && !to_hit_c) begin
      par_go_c = 1'b1;
      set_c    = 2'b11;
    end else if (state == IDLE && !bus.par_valid && !fifo_empty && (|free_c)) begin
      fifo_pop_c = 1'b1;
      ser_core_c = !free_c[0];
      set_c      = free_c[0] ? 2'b01 : 2'b10;
    end
    inflight_nxt_c = (inflight & ~done_c) | set_c;
    if (to_hit_c) begin
      inflight_nxt_c = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      inflight       <= '0;
      core_valid_q   <= '0;
      core_id_q      <= '0;
      core_data0_q   <= '0;
      core_data1_q   <= '0;
      pend_valid     <= 1'b0;
      pend_id        <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_par_q   <= 1'b0;
      par_ready_q    <= 1'b0;
    end else begin
      inflight       <= inflight_nxt_c;
      core_valid_q   <= set_c;
      par_ready_q    <= par_go_c;
      commit_valid_q <= 1'b0;
      commit_par_q   <= 1'b0;

      if (par_go_c) begin
        core_id_q    <= {bus.par_id, bus.par_id};
        core_data0_q <= bus.par_data0;
        core_data1_q <= bus.par_data1;
      end else if (fifo_pop_c) begin
        core_id_q[ser_core_c] <= fifo_head.id;
        if (ser_core_c) begin
          core_data1_q <= fifo_head.data;
        end else begin
          core_data0_q <= fifo_head.data;
        end
      end

      case (state)
        IDLE: begin
          if (par_go_c) begin
            state <= PAR_RUN;
          end else if (bus.par_valid) begin
            state <= PAR_DRAIN;
          end
        end
        PAR_DRAIN: begin
          if (par_go_c) begin
            state <= PAR_RUN;
          end else if (!bus.par_valid) begin
            state <= IDLE;
          end
        end
        PAR_RUN: begin
          // Both halves carry the pair id, so core 0's latched id is reported.
          if (inflight_nxt_c == 2'b00) begin
            state          <= IDLE;
            commit_valid_q <= 1'b1;
            commit_id_q    <= core_id_q[0];
            commit_par_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Serial commits: core 0 wins a tie, core 1 is replayed next cycle.
      if (state != PAR_RUN) begin
        if (pend_valid) begin
          commit_valid_q <= 1'b1;
          commit_id_q    <= pend_id;
          pend_valid     <= 1'b0;
        end else if (done_c[0]) begin
          commit_valid_q <= 1'b1;
          commit_id_q    <= core_id_q[0];
          if (done_c[1]) begin
            pend_valid <= 1'b1;
            pend_id    <= core_id_q[1];
          end
        end else if (done_c[1]) begin
          commit_valid_q <= 1'b1;
          commit_id_q    <= core_id_q[1];
        end
      end

      if (to_hit_c) begin
        state          <= IDLE;
        commit_valid_q <= 1'b0;
        commit_par_q   <= 1'b0;
        pend_valid     <= 1'b0;
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_err_q;

  assign to_hit_c = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts every cycle spent waiting on a pair; restarts on each return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state == IDLE || to_hit_c) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (to_hit_c) begin
        to_err_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = to_err_q;
`else
  assign to_hit_c        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.ser_ready    = !fifo_full;
  assign bus.par_ready    = par_ready_q;
  assign bus.core_valid   = core_valid_q;
  assign bus.core_id0     = core_id_q[0];
  assign bus.core_id1     = core_id_q[1];
  assign bus.core_data0   = core_data0_q;
  assign bus.core_data1   = core_data1_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_id    = commit_id_q;
  assign bus.commit_par   = commit_par_q;

endmodule

// File: tb/tb_nebula_dispatch_sched.sv
// Directed self-checking bench for nebula_dispatch_sched (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_nebula_dispatch_sched;
  import nebula_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nebula_dispatch_sched_if bus();

  nebula_dispatch_sched #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic blk_data_t mk(input logic [7:0] id);
    blk_data_t d;
    for (int w = 0; w < 4; w++) d[w] = {id, 8'(w), 16'hBEEF};
    return d;
  endfunction

  task automatic ser(input logic [7:0] id);
    bus.ser_valid = 1'b1;
    bus.ser_id    = id;
    bus.ser_data  = mk(id);
  endtask

  task automatic par(input logic [7:0] id);
    bus.par_valid = 1'b1;
    bus.par_id    = id;
    bus.par_data0 = mk(id);
    bus.par_data1 = mk(id ^ 8'h80);
  endtask

  initial begin
    rst             = 1'b1;
    bus.ser_valid   = 1'b0;
    bus.ser_id      = '0;
    bus.ser_data    = '0;
    bus.par_valid   = 1'b0;
    bus.par_id      = '0;
    bus.par_data0   = '0;
    bus.par_data1   = '0;
    bus.core_busy   = 2'b00;
    bus.core_commit = 2'b00;
    step(); step();
    chk("rst_ser_ready",    bus.ser_ready, 1'b1);
    chk("rst_par_ready",    bus.par_ready, 1'b0);
    chk("rst_core_valid",   bus.core_valid, 2'b00);
    chk("rst_core_id0",     bus.core_id0, 8'h00);
    chk("rst_commit_valid", bus.commit_valid, 1'b0);
    chk("rst_timeout_err",  bus.timeout_err, 1'b0);
    rst = 1'b0;

    // Serial dispatch to the lowest free core, then commits
    ser(8'h10); step();
    chk("ser_no_early", bus.core_valid, 2'b00);
    ser(8'h11); step();
    chk("ser0_valid", bus.core_valid, 2'b01);
    chk("ser0_id",    bus.core_id0, 8'h10);
    chk("ser0_data",  bus.core_data0, mk(8'h10));
    bus.ser_valid = 1'b0; step();
    chk("ser1_valid",   bus.core_valid, 2'b10);
    chk("ser1_id",      bus.core_id1, 8'h11);
    chk("ser0_id_hold", bus.core_id0, 8'h10);
    bus.core_commit = 2'b01; step();
    chk("sc0_valid", bus.commit_valid, 1'b1);
    chk("sc0_id",    bus.commit_id, 8'h10);
    chk("sc0_par",   bus.commit_par, 1'b0);
    bus.core_commit = 2'b10; step();
    chk("sc1_valid", bus.commit_valid, 1'b1);
    chk("sc1_id",    bus.commit_id, 8'h11);
    bus.core_commit = 2'b00; step();
    chk("sc_idle", bus.commit_valid, 1'b0);

    // Parallel pair, commits on different cycles
    par(8'h20); step();
    chk("par_ready", bus.par_ready, 1'b1);
    chk("par_valid", bus.core_valid, 2'b11);
    chk("par_data0", bus.core_data0, mk(8'h20));
    chk("par_data1", bus.core_data1, mk(8'hA0));
    chk("par_id1",   bus.core_id1, 8'h20);
    bus.par_valid = 1'b0; bus.core_commit = 2'b01; step();
    chk("par_half_commit", bus.commit_valid, 1'b0);
    chk("par_ready_drop",  bus.par_ready, 1'b0);
    bus.core_commit = 2'b00; step(); step();
    bus.core_commit = 2'b10; step();
    chk("pc_valid", bus.commit_valid, 1'b1);
    chk("pc_id",    bus.commit_id, 8'h20);
    chk("pc_par",   bus.commit_par, 1'b1);
    bus.core_commit = 2'b00; step();
    chk("pc_single", bus.commit_valid, 1'b0);

    // Drain before parallel issue; queued serial block waits behind the pair
    ser(8'h30); step();
    bus.ser_valid = 1'b0; step();
    chk("dr_ser_valid", bus.core_valid, 2'b01);
    chk("dr_ser_id",    bus.core_id0, 8'h30);
    par(8'h31); ser(8'h32); step();
    chk("dr_hold_valid", bus.core_valid, 2'b00);
    chk("dr_hold_ready", bus.par_ready, 1'b0);
    bus.ser_valid = 1'b0; step();
    chk("dr_hold2_valid", bus.core_valid, 2'b00);
    bus.core_commit = 2'b01; step();
    chk("dr_commit_id", bus.commit_id, 8'h30);
    chk("dr_still_off", bus.core_valid, 2'b00);
    bus.core_commit = 2'b00; step();
    chk("dr_par_valid", bus.core_valid, 2'b11);
    chk("dr_par_ready", bus.par_ready, 1'b1);
    chk("dr_par_id",    bus.core_id0, 8'h31);
    bus.par_valid = 1'b0; bus.core_commit = 2'b11; step();
    chk("dr_pc_id",  bus.commit_id, 8'h31);
    chk("dr_pc_par", bus.commit_par, 1'b1);
    bus.core_commit = 2'b00; step();
    chk("dr_ser_after", bus.core_valid, 2'b01);
    chk("dr_ser_after_id", bus.core_id0, 8'h32);

    // Simultaneous serial commits: core 0 then core 1
    bus.core_commit = 2'b01; step();
    chk("sim_pre_id", bus.commit_id, 8'h32);
    bus.core_commit = 2'b00;
    ser(8'h40); step();
    ser(8'h41); step();
    chk("sim_d0", bus.core_id0, 8'h40);
    bus.ser_valid = 1'b0; step();
    chk("sim_d1_valid", bus.core_valid, 2'b10);
    chk("sim_d1",       bus.core_id1, 8'h41);
    bus.core_commit = 2'b11; step();
    chk("sim_c0_valid", bus.commit_valid, 1'b1);
    chk("sim_c0_id",    bus.commit_id, 8'h40);
    chk("sim_c0_par",   bus.commit_par, 1'b0);
    bus.core_commit = 2'b00; step();
    chk("sim_c1_valid", bus.commit_valid, 1'b1);
    chk("sim_c1_id",    bus.commit_id, 8'h41);
    step();
    chk("sim_done", bus.commit_valid, 1'b0);

    // FIFO full with busy cores, one pop, then mid-run reset
    bus.core_busy = 2'b11;
    ser(8'h50); step();
    ser(8'h51); step();
    ser(8'h52); step();
    chk("ff_ready_3", bus.ser_ready, 1'b1);
    ser(8'h53); step();
    chk("ff_full", bus.ser_ready, 1'b0);
    ser(8'h54); step();
    chk("ff_full_hold", bus.ser_ready, 1'b0);
    chk("ff_no_disp",   bus.core_valid, 2'b00);
    bus.core_busy = 2'b01; step();
    chk("ff_pop_valid", bus.core_valid, 2'b10);
    chk("ff_pop_id",    bus.core_id1, 8'h50);
    chk("ff_ready_pop", bus.ser_ready, 1'b1);
    rst = 1'b1; bus.ser_valid = 1'b0; step();
    chk("mr_ser_ready", bus.ser_ready, 1'b1);
    chk("mr_core_valid", bus.core_valid, 2'b00);
    chk("mr_core_id1",  bus.core_id1, 8'h00);
    rst = 1'b0; bus.core_busy = 2'b00; step();
    chk("mr_flushed", bus.core_valid, 2'b00);
    ser(8'h60); step();
    ser(8'h61); step();
    chk("mr_d0", bus.core_id0, 8'h60);
    bus.ser_valid = 1'b0; step();
    chk("mr_d1_valid", bus.core_valid, 2'b10);
    chk("mr_d1",       bus.core_id1, 8'h61);
    bus.core_commit = 2'b11; step();
    chk("mr_c0", bus.commit_id, 8'h60);
    bus.core_commit = 2'b00; step();
    chk("mr_c1", bus.commit_id, 8'h61);
    step();

    // Pair issued with no commits for a long stretch
    par(8'h70); step();
    chk("to_par_valid", bus.core_valid, 2'b11);
    bus.par_valid = 1'b0;
    repeat (15) step();
    chk("to_err_early",  bus.timeout_err, 1'b0);
    chk("to_no_commit",  bus.commit_valid, 1'b0);
    step();
`ifdef DISPATCH_TIMEOUT_EN
    chk("to_err_set",    bus.timeout_err, 1'b1);
    chk("to_no_commit2", bus.commit_valid, 1'b0);
    ser(8'h71); step();
    bus.ser_valid = 1'b0; step();
    chk("to_idle_disp", bus.core_valid, 2'b01);
    chk("to_idle_id",   bus.core_id0, 8'h71);
    chk("to_err_sticky", bus.timeout_err, 1'b1);
    bus.core_commit = 2'b01; step();
    chk("to_c_id", bus.commit_id, 8'h71);
    bus.core_commit = 2'b00; step();
`else
    chk("to_err_off",  bus.timeout_err, 1'b0);
    chk("to_waiting",  bus.commit_valid, 1'b0);
    bus.core_commit = 2'b11; step();
    chk("to_pc_valid", bus.commit_valid, 1'b1);
    chk("to_pc_id",    bus.commit_id, 8'h70);
    chk("to_pc_par",   bus.commit_par, 1'b1);
    bus.core_commit = 2'b00; step();
`endif

    // Commit on a core with nothing in flight is ignored
    bus.core_commit = 2'b10; step();
    chk("ign_commit", bus.commit_valid, 1'b0);
    bus.core_commit = 2'b00; step();
    chk("ign_commit2", bus.commit_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
